// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game: colour codes, button count and
// helpers used by the input front end.
package simon_pkg;

    localparam int unsigned N_BTN               = 4;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] GREEN  = 2'd1;
    localparam logic [1:0] BLUE   = 2'd2;
    localparam logic [1:0] YELLOW = 2'd3;

    function automatic logic [2:0] popcount_btn(input logic [N_BTN-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < N_BTN; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Index of the highest set bit; callers guarantee exactly one bit is set.
    function automatic logic [1:0] btn_index(input logic [N_BTN-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < N_BTN; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button: two-flop synchroniser followed by a stable-level debouncer that
// only accepts a change after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q;
    logic             synced_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 1'b0;
            synced_q <= 1'b0;
            cnt_q    <= '0;
            stable   <= 1'b0;
        end else begin
            sync_q   <= raw;
            synced_q <= sync_q;
            if (synced_q == stable) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                stable <= synced_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_input.sv
// Simon push-button front end: debounced levels, single-press qualification and
// a one-entry valid/ready event buffer with multi-press and overflow pulses.
module button_input
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_code,
    output logic [N_BTN-1:0] btn_level,
    output logic             multi_press,
    output logic             overflow
);

    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] stable_prev_q;
    logic [N_BTN-1:0] press;
    logic [2:0]       pop;
    logic             single_press;
    logic             many_press;

    for (genvar i = 0; i < N_BTN; i++) begin : g_deb
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .stable(stable[i])
        );
    end

    assign btn_level = stable;

    always_comb begin
        press        = stable & ~stable_prev_q;
        pop          = popcount_btn(stable);
        single_press = (press != '0) && (pop == 3'd1);
        many_press   = (press != '0) && (pop > 3'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_prev_q <= '0;
            evt_valid     <= 1'b0;
            evt_code      <= RED;
            multi_press   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            // Edge detect keeps tracking while disabled so a held button never
            // turns into an event when enable rises.
            stable_prev_q <= stable;
            multi_press   <= 1'b0;
            overflow      <= 1'b0;
            if (!enable) begin
                evt_valid <= 1'b0;
            end else if (many_press) begin
                multi_press <= 1'b1;
                if (evt_valid && evt_ready) evt_valid <= 1'b0;
            end else if (single_press) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_code  <= btn_index(stable);
                end else begin
                    overflow <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_input.sv
// Bench for button_input: directed vector table, hand-written corner sequences
// and randomised stimulus against a history-based reference model.
module tb_button_input;
    import simon_pkg::*;

    localparam int D = DEBOUNCE_CYCLES_SIM;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic       enable;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic [3:0] btn_level;
    logic       multi_press;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    button_input #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .enable     (enable),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .btn_level  (btn_level),
        .multi_press(multi_press),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a level is accepted once D consecutive synchronised
    // samples (raw delayed two edges) all disagree with the accepted level.
    logic [3:0] m_hist[$];
    logic [3:0] m_stable = '0;
    logic [3:0] m_prev   = '0;
    logic       m_valid  = 1'b0;
    logic [1:0] m_code   = '0;
    logic       m_multi  = 1'b0;
    logic       m_ovf    = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_hist.delete();
                repeat (D + 2) m_hist.push_back(4'b0000);
                m_stable = '0;
                m_prev   = '0;
                m_valid  = 1'b0;
                m_code   = '0;
                m_multi  = 1'b0;
                m_ovf    = 1'b0;
            end else begin
                logic [3:0] press;
                int         pop;
                press   = m_stable & ~m_prev;
                pop     = $countones(m_stable);
                m_multi = 1'b0;
                m_ovf   = 1'b0;
                if (!enable) begin
                    m_valid = 1'b0;
                end else if (press != 0 && pop >= 2) begin
                    m_multi = 1'b1;
                    if (m_valid && evt_ready) m_valid = 1'b0;
                end else if (press != 0 && pop == 1) begin
                    if (!m_valid || evt_ready) begin
                        m_valid = 1'b1;
                        for (int b = 0; b < 4; b++) if (m_stable[b]) m_code = 2'(b);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else if (m_valid && evt_ready) begin
                    m_valid = 1'b0;
                end
                m_prev = m_stable;
                m_hist.push_front(btn_raw);
                void'(m_hist.pop_back());
                for (int b = 0; b < 4; b++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int j = 2; j <= D + 1; j++) begin
                        if (m_hist[j][b] == m_stable[b]) all_diff = 1'b0;
                    end
                    if (all_diff) m_stable[b] = ~m_stable[b];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && m_hist.size() != 0) begin
                check("model_level", btn_level, m_stable);
                check("model_valid", evt_valid, m_valid);
                if (m_valid) check("model_code", evt_code, m_code);
                check("model_multi", multi_press, m_multi);
                check("model_ovf", overflow, m_ovf);
            end
        end
    end

    typedef struct {
        logic [3:0] raw;
        logic       en;
        logic       rdy;
        int         edges;
        logic [3:0] lvl;
        logic       v;
        logic [1:0] code;
        logic       m;
        logic       o;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] raw, input logic en, input logic rdy, input int edges,
                       input logic [3:0] lvl, input logic v, input logic [1:0] code,
                       input logic m, input logic o);
        vec_t t;
        t = '{raw, en, rdy, edges, lvl, v, code, m, o};
        tbl.push_back(t);
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_raw   = 4'b1111;
        enable    = 1'b1;
        evt_ready = 1'b0;

        // raw, en, rdy, edges, level, valid, code, multi, ovf
        add(4'b0000, 1, 0, 8, 4'b0000, 0, RED,    0, 0);
        add(4'b0100, 1, 0, 5, 4'b0000, 0, RED,    0, 0);
        add(4'b0100, 1, 0, 1, 4'b0100, 0, RED,    0, 0);
        add(4'b0100, 1, 0, 1, 4'b0100, 1, BLUE,   0, 0);
        add(4'b0100, 1, 0, 3, 4'b0100, 1, BLUE,   0, 0);
        add(4'b0100, 1, 1, 1, 4'b0100, 0, RED,    0, 0);
        add(4'b0000, 1, 0, 8, 4'b0000, 0, RED,    0, 0);
        add(4'b0001, 1, 0, 1, 4'b0000, 0, RED,    0, 0);
        add(4'b0000, 1, 0, 1, 4'b0000, 0, RED,    0, 0);
        add(4'b0001, 1, 0, 1, 4'b0000, 0, RED,    0, 0);
        add(4'b0000, 1, 0, 1, 4'b0000, 0, RED,    0, 0);
        add(4'b0001, 1, 0, 5, 4'b0000, 0, RED,    0, 0);
        add(4'b0001, 1, 0, 1, 4'b0001, 0, RED,    0, 0);
        add(4'b0001, 1, 0, 1, 4'b0001, 1, RED,    0, 0);
        add(4'b0001, 1, 1, 1, 4'b0001, 0, RED,    0, 0);
        add(4'b0000, 1, 0, 8, 4'b0000, 0, RED,    0, 0);
        add(4'b0010, 1, 0, 7, 4'b0010, 1, GREEN,  0, 0);
        add(4'b0010, 1, 1, 1, 4'b0010, 0, RED,    0, 0);
        add(4'b1010, 1, 0, 6, 4'b1010, 0, RED,    0, 0);
        add(4'b1010, 1, 0, 1, 4'b1010, 0, RED,    1, 0);
        add(4'b1010, 1, 0, 1, 4'b1010, 0, RED,    0, 0);
        add(4'b0000, 1, 0, 8, 4'b0000, 0, RED,    0, 0);
        add(4'b0001, 1, 0, 7, 4'b0001, 1, RED,    0, 0);
        add(4'b0000, 1, 0, 8, 4'b0000, 1, RED,    0, 0);
        add(4'b1000, 1, 0, 6, 4'b1000, 1, RED,    0, 0);
        add(4'b1000, 1, 0, 1, 4'b1000, 1, RED,    0, 1);
        add(4'b1000, 1, 0, 1, 4'b1000, 1, RED,    0, 0);
        add(4'b0000, 1, 0, 8, 4'b0000, 1, RED,    0, 0);
        add(4'b1000, 1, 0, 6, 4'b1000, 1, RED,    0, 0);
        add(4'b1000, 1, 1, 1, 4'b1000, 1, YELLOW, 0, 0);
        add(4'b1000, 1, 1, 1, 4'b1000, 0, RED,    0, 0);
        add(4'b0000, 1, 0, 8, 4'b0000, 0, RED,    0, 0);
        add(4'b0100, 0, 0, 7, 4'b0100, 0, RED,    0, 0);
        add(4'b0100, 1, 0, 8, 4'b0100, 0, RED,    0, 0);
        add(4'b0000, 1, 0, 8, 4'b0000, 0, RED,    0, 0);
        add(4'b0100, 1, 0, 7, 4'b0100, 1, BLUE,   0, 0);
        add(4'b0100, 0, 0, 1, 4'b0100, 0, RED,    0, 0);

        // Reset with all buttons held, then release reset while still held.
        tick(3);
        check("rst_level", btn_level, 4'b0000);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_code", evt_code, 2'd0);
        check("rst_multi", multi_press, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        tick(5);
        check("rel_level_early", btn_level, 4'b0000);
        tick(1);
        check("rel_level", btn_level, 4'b1111);
        check("rel_valid", evt_valid, 1'b0);
        tick(1);
        check("rel_multi", multi_press, 1'b1);
        check("rel_valid2", evt_valid, 1'b0);
        tick(1);
        check("rel_multi_end", multi_press, 1'b0);

        foreach (tbl[i]) begin
            btn_raw   = tbl[i].raw;
            enable    = tbl[i].en;
            evt_ready = tbl[i].rdy;
            tick(tbl[i].edges);
            check($sformatf("vec%0d_level", i), btn_level, tbl[i].lvl);
            check($sformatf("vec%0d_valid", i), evt_valid, tbl[i].v);
            if (tbl[i].v) check($sformatf("vec%0d_code", i), evt_code, tbl[i].code);
            check($sformatf("vec%0d_multi", i), multi_press, tbl[i].m);
            check($sformatf("vec%0d_ovf", i), overflow, tbl[i].o);
        end

        // Reset with an event pending must discard it.
        evt_ready = 1'b0;
        rst_n     = 1'b0;
        tick(1);
        check("midrst_valid", evt_valid, 1'b0);
        check("midrst_level", btn_level, 4'b0000);
        rst_n = 1'b1;
        tick(1);

        // Randomised phase, checked only through the reference model.
        for (int it = 0; it < 400; it++) begin
            logic [3:0] r;
            int         hold;
            case ($urandom_range(0, 3))
                0:       r = 4'b0000;
                1, 2:    r = 4'b0001 << $urandom_range(0, 3);
                default: r = 4'($urandom_range(0, 15));
            endcase
            hold    = $urandom_range(1, 8);
            btn_raw = r;
            enable  = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < hold; c++) begin
                evt_ready = 1'($urandom_range(0, 1));
                tick(1);
            end
            if (it % 97 == 96) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
        end

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
